// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - pc_sel encodings and shared sizing helpers for the PC sequencer
package pc_sequencer_pkg;

    localparam int PC_ADDR_W_DEFAULT = 16;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PC_SEL_SEQ    = 2'b00;
    localparam pc_sel_t PC_SEL_BRANCH = 2'b01;
    localparam pc_sel_t PC_SEL_JUMP   = 2'b10;
    localparam pc_sel_t PC_SEL_RET    = 2'b11;

    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W    = PC_ADDR_W_DEFAULT,
    parameter int RAS_DEPTH = 8,
    localparam int PTR_W    = $clog2(RAS_DEPTH),
    localparam int CNT_W    = ras_cnt_w(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [ADDR_W-1:0] entry_q [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d, sp_inc, sp_dec;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign sp_inc  = (sp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp_q + 1'b1;
    assign sp_dec  = (sp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : sp_q - 1'b1;
    assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign top_o   = entry_q[sp_dec];
    assign count_o = cnt_q;

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push_i) begin
            sp_d = sp_inc;
            if (!full_o) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_i && !empty_o) begin
            sp_d  = sp_dec;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (reset_n && push_i) begin
            entry_q[sp_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC select with return-address stack; PC_TRAP_EN redirects RAS faults to TRAP_VEC
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = PC_ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = 'hFFF0,
    localparam int               CNT_W     = ras_cnt_w(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [1:0]        pc_sel,
    input  logic              branch_taken,
    input  logic              call,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_err,
    output logic              trap
);

`ifdef PC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              err_q, err_d;
    logic              push, pop, fault;
    logic              ras_full, ras_empty;
    logic [ADDR_W-1:0] ras_top;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_plus1),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    assign pc_plus1 = pc_q + 1'b1;
    assign pc_out   = pc_q;
    assign ras_err  = err_q;

    assign fault = !stall &&
                   (((pc_sel == PC_SEL_JUMP) && call && ras_full) ||
                    ((pc_sel == PC_SEL_RET) && ras_empty));

    always_comb begin
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        err_d = err_q | fault;
        if (!stall) begin
            if (TRAP_EN && fault) begin
                pc_d = TRAP_VEC;
            end else begin
                case (pc_sel)
                    PC_SEL_SEQ:    pc_d = pc_plus1;
                    PC_SEL_BRANCH: pc_d = branch_taken ? target : pc_plus1;
                    PC_SEL_JUMP: begin
                        pc_d = target;
                        push = call;
                    end
                    default: begin
                        if (ras_empty) begin
                            pc_d = pc_plus1;
                        end else begin
                            pc_d = ras_top;
                            pop  = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

`ifdef PC_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= fault;
        end
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed-vector bench for pc_sequencer (ADDR_W=16, RAS_DEPTH=4)
module tb_pc_sequencer;

    localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, JMP = 2'b10, RET = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic        call;
    logic [15:0] target;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1;
    logic [2:0]  ras_count;
    logic        ras_err;
    logic        trap;

    int vectors = 0;
    int miscompares = 0;

    pc_sequencer #(
        .ADDR_W    (16),
        .RESET_VEC (16'h0000),
        .RAS_DEPTH (4),
        .TRAP_VEC  (16'hFFF0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .call         (call),
        .target       (target),
        .pc_out       (pc_out),
        .pc_plus1     (pc_plus1),
        .ras_count    (ras_count),
        .ras_err      (ras_err),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic st, input logic [1:0] sel,
                       input logic tk, input logic cl, input logic [15:0] tgt);
        reset_n      = rn;
        stall        = st;
        pc_sel       = sel;
        branch_taken = tk;
        call         = cl;
        target       = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] pc, input logic [2:0] cnt,
                             input logic err, input logic trp);
        chk({tag, ".pc"},    {16'h0, pc_out},    {16'h0, pc});
        chk({tag, ".count"}, {29'h0, ras_count}, {29'h0, cnt});
        chk({tag, ".err"},   {31'h0, ras_err},   {31'h0, err});
        chk({tag, ".trap"},  {31'h0, trap},      {31'h0, trp});
    endtask

    initial begin
        logic trap_build;
        logic [15:0] ret_exp [4];
`ifdef PC_TRAP_EN
        trap_build = 1'b1;
        ret_exp = '{16'h0401, 16'h0301, 16'h0201, 16'h0012};
`else
        trap_build = 1'b0;
        ret_exp = '{16'h0501, 16'h0401, 16'h0301, 16'h0201};
`endif
        #2;

        // 1. reset, sequential fetch, stall hold
        cyc(1'b0, 1'b0, SEQ, 1'b0, 1'b0, 16'h0);
        chk_state("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        chk("reset.plus1", {16'h0, pc_plus1}, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, SEQ, 1'b0, 1'b0, 16'h0);
            chk_state($sformatf("seq%0d", i), 16'(i), 3'd0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, SEQ, 1'b0, 1'b0, 16'h0);
            chk("stall.pc", {16'h0, pc_out}, 32'h3);
        end

        // 2. wrap and branch qualification (call ignored on BRANCH)
        cyc(1'b1, 1'b0, JMP, 1'b0, 1'b0, 16'hFFFF);
        chk("jmp_ffff.pc", {16'h0, pc_out}, 32'hFFFF);
        chk("wrap.plus1", {16'h0, pc_plus1}, 32'h0);
        cyc(1'b1, 1'b0, SEQ, 1'b0, 1'b0, 16'h0);
        chk("wrap.pc", {16'h0, pc_out}, 32'h0);
        cyc(1'b1, 1'b0, BR, 1'b0, 1'b1, 16'h0040);
        chk_state("br_nt", 16'h0001, 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, BR, 1'b1, 1'b1, 16'h0040);
        chk_state("br_t", 16'h0040, 3'd0, 1'b0, 1'b0);

        // 3. single call / return
        cyc(1'b1, 1'b0, JMP, 1'b0, 1'b0, 16'h0010);
        cyc(1'b1, 1'b0, JMP, 1'b0, 1'b1, 16'h0100);
        chk_state("call1", 16'h0100, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, RET, 1'b0, 1'b1, 16'h0);
        chk_state("ret1", 16'h0011, 3'd0, 1'b0, 1'b0);

        // 4. five nested calls: overflow, four returns, underflow
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, JMP, 1'b0, 1'b1, 16'(16'h0200 + 16'h0100 * i));
            chk_state($sformatf("nest%0d", i), 16'(16'h0200 + 16'h0100 * i), 3'(i + 1), 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0, JMP, 1'b0, 1'b1, 16'h0600);
        chk_state("ovf", trap_build ? 16'hFFF0 : 16'h0600, 3'd4, 1'b1, trap_build);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, RET, 1'b0, 1'b0, 16'h0);
            chk_state($sformatf("unwind%0d", i), ret_exp[i], 3'(3 - i), 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b0, RET, 1'b0, 1'b0, 16'h0);
        chk_state("unf", trap_build ? 16'hFFF0 : 16'(ret_exp[3] + 16'h1), 3'd0, 1'b1, trap_build);
        cyc(1'b1, 1'b0, JMP, 1'b0, 1'b0, 16'h0700);
        chk_state("after_unf", 16'h0700, 3'd0, 1'b1, 1'b0);

        // 5. reset wins over a pending RET
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, JMP, 1'b0, 1'b1, 16'(16'h0800 + 16'h0100 * i));
        end
        chk_state("pre_rst", 16'h0A00, 3'd3, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, RET, 1'b0, 1'b0, 16'h0);
        chk_state("mid_rst", 16'h0000, 3'd0, 1'b0, 1'b0);

        // 6. stalled call is held, then taken exactly once
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, JMP, 1'b0, 1'b1, 16'h0A00);
            chk_state("stall_call", 16'h0000, 3'd0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0, JMP, 1'b0, 1'b1, 16'h0A00);
        chk_state("call_go", 16'h0A00, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, SEQ, 1'b0, 1'b1, 16'h0);
        chk_state("call_once", 16'h0A01, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, RET, 1'b0, 1'b0, 16'h0);
        chk_state("call_ret", 16'h0001, 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
